delta_sigma_dac: RTL

//  - 2nd-order 1-bit delta-sigma modulator driving the audio PDM/DAC pin.
//  - Consumes the held 16x-upsampled signed sample from the upsampler (updates every 142 clk).
//  - Runs one modulator update every MOD_DIV clocks.
//  - Soft-mute gain ramp prevents clicks at mute/unmute.

---
 rtl/dsm_pkg.sv | 23 ++
 rtl/dsm_lfsr.sv | 31 +++
 rtl/delta_sigma_dac.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dsm_pkg.sv
// Shared types and constants for the 2nd-order delta-sigma audio DAC.
// Dither LFSR constants are used only when DELTA_SIGMA_DITHER_EN is defined.
package dsm_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } dsm_state_t;

    localparam int          DSM_FB_MAG = 32768;
    localparam int          DSM_X_LIM  = 24576;
    localparam int          GAIN_MAX   = 256;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // Right-shifting Galois step: feedback taps apply when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/dsm_lfsr.sv
// 16-bit Galois LFSR that supplies a 4-bit signed dither value to the quantiser.
// Advances once per modulator tick.
module dsm_lfsr
    import dsm_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       adv_i,
    output logic [3:0] dither_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither_o = lfsr_q[3:0];

endmodule

// File: rtl/delta_sigma_dac.sv
// 2nd-order 1-bit delta-sigma modulator with soft-mute gain ramp.
// Define DELTA_SIGMA_DITHER_EN to add LFSR dither at the quantiser input.
module delta_sigma_dac
    import dsm_pkg::*;
#(
    parameter int unsigned MOD_DIV         = 2,
    parameter int unsigned ACC_W           = 24,
    parameter int unsigned RAMP_STEP_TICKS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] sample_in,
    input  logic               mute_req,
    output logic               pdm_out,
    output logic               muted
);

    localparam int unsigned DIV_W  = (MOD_DIV > 1) ? $clog2(MOD_DIV) : 1;
    localparam int unsigned RAMP_W = (RAMP_STEP_TICKS > 1) ? $clog2(RAMP_STEP_TICKS) : 1;
    localparam int unsigned SUM_W  = ACC_W + 2;
    localparam int unsigned PROD_W = 26;

    localparam logic signed [SUM_W-1:0]  ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]  ACC_MIN = -ACC_MAX;
    localparam logic signed [SUM_W-1:0]  FB_POS  = SUM_W'(DSM_FB_MAG);
    localparam logic signed [SUM_W-1:0]  FB_NEG  = -FB_POS;
    localparam logic signed [PROD_W-1:0] X_HI    = PROD_W'(DSM_X_LIM);
    localparam logic signed [PROD_W-1:0] X_LO    = -X_HI;

    dsm_state_t               state_q, state_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [RAMP_W-1:0]        ramp_q, ramp_d;
    logic [8:0]               gain_q, gain_d;
    logic signed [ACC_W-1:0]  int1_q, int1_d, int2_q, int2_d;
    logic                     pdm_q, pdm_d;
    logic                     muted_q, muted_d;

    logic                     tick;
    logic                     ramp_last;
    logic signed [PROD_W-1:0] prod, scaled;
    logic signed [SUM_W-1:0]  x_w, fb, sum1, sum2, q;
    logic signed [ACC_W-1:0]  int1_n, int2_n;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v > ACC_MAX) begin
            sat_acc = ACC_W'(ACC_MAX);
        end else if (v < ACC_MIN) begin
            sat_acc = ACC_W'(ACC_MIN);
        end else begin
            sat_acc = ACC_W'(v);
        end
    endfunction

    assign tick      = (div_q == DIV_W'(MOD_DIV - 1));
    assign ramp_last = (ramp_q == RAMP_W'(RAMP_STEP_TICKS - 1));

`ifdef DELTA_SIGMA_DITHER_EN
    logic [3:0] dither;

    dsm_lfsr u_lfsr (
        .clk_i    (clk),
        .rst_i    (rst),
        .adv_i    (tick),
        .dither_o (dither)
    );
`endif

    // Modulator datapath, evaluated every cycle but only committed on tick.
    always_comb begin
        prod   = PROD_W'(sample_in) * PROD_W'($signed({1'b0, gain_q}));
        scaled = prod >>> 8;
        if (scaled > X_HI) begin
            x_w = SUM_W'(X_HI);
        end else if (scaled < X_LO) begin
            x_w = SUM_W'(X_LO);
        end else begin
            x_w = SUM_W'(scaled);
        end
        fb     = pdm_q ? FB_POS : FB_NEG;
        sum1   = SUM_W'(int1_q) + x_w - fb;
        int1_n = sat_acc(sum1);
        sum2   = SUM_W'(int2_q) + SUM_W'(int1_n) - fb;
        int2_n = sat_acc(sum2);
`ifdef DELTA_SIGMA_DITHER_EN
        q      = SUM_W'(int2_n) + SUM_W'($signed(dither));
`else
        q      = SUM_W'(int2_n);
`endif
    end

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        ramp_d  = ramp_q;
        gain_d  = gain_q;
        int1_d  = int1_q;
        int2_d  = int2_q;
        pdm_d   = pdm_q;
        muted_d = muted_q;

        if (tick) begin
            if (state_q == MUTED) begin
                pdm_d  = ~pdm_q;
                int1_d = '0;
                int2_d = '0;
            end else begin
                int1_d = int1_n;
                int2_d = int2_n;
                pdm_d  = ~q[SUM_W-1];
            end

            unique case (state_q)
                MUTED: begin
                    if (!mute_req) begin
                        state_d = RAMP_UP;
                        muted_d = 1'b0;
                        ramp_d  = '0;
                    end
                end
                RAMP_UP: begin
                    if (mute_req) begin
                        state_d = RAMP_DOWN;
                        ramp_d  = '0;
                    end else if (gain_q == 9'(GAIN_MAX)) begin
                        state_d = RUN;
                        ramp_d  = '0;
                    end else if (ramp_last) begin
                        ramp_d = '0;
                        gain_d = gain_q + 9'd1;
                        if (gain_q == 9'(GAIN_MAX - 1)) begin
                            state_d = RUN;
                        end
                    end else begin
                        ramp_d = ramp_q + 1'b1;
                    end
                end
                RUN: begin
                    gain_d = 9'(GAIN_MAX);
                    if (mute_req) begin
                        state_d = RAMP_DOWN;
                        ramp_d  = '0;
                    end
                end
                RAMP_DOWN: begin
                    if (!mute_req) begin
                        state_d = RAMP_UP;
                        ramp_d  = '0;
                    end else if (gain_q == 9'd0 || (ramp_last && gain_q == 9'd1)) begin
                        // Landing on zero gain: park the loop with clean integrators.
                        state_d = MUTED;
                        muted_d = 1'b1;
                        gain_d  = 9'd0;
                        ramp_d  = '0;
                        int1_d  = '0;
                        int2_d  = '0;
                    end else if (ramp_last) begin
                        ramp_d = '0;
                        gain_d = gain_q - 9'd1;
                    end else begin
                        ramp_d = ramp_q + 1'b1;
                    end
                end
                default: state_d = MUTED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUTED;
            div_q   <= '0;
            ramp_q  <= '0;
            gain_q  <= 9'd0;
            int1_q  <= '0;
            int2_q  <= '0;
            pdm_q   <= 1'b0;
            muted_q <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ramp_q  <= ramp_d;
            gain_q  <= gain_d;
            int1_q  <= int1_d;
            int2_q  <= int2_d;
            pdm_q   <= pdm_d;
            muted_q <= muted_d;
        end
    end

    assign pdm_out = pdm_q;
    assign muted   = muted_q;

endmodule
